// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multi-cycle RISC-V control sequencer with retired-instruction counter
module riscv_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             Zero_flg,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // ALU operand / operation encodings as seen by the datapath muxes
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_RS1   = 2'b01;
  localparam logic [1:0] A_OLDPC = 2'b10;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_FOUR  = 2'b01;
  localparam logic [1:0] B_IMM   = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_FUNC = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_ALU_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t state;
  state_t state_next;

  // State register; reset aborts any in-flight instruction at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Next-state logic and Moore-style output decode (mem_ready/Zero_flg gate a few strobes)
  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = A_PC;
    ALUSrcB    = B_RS2;
    ALUOp      = OP_ADD;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        // Instruction read from PC while the ALU computes PC+4
        MemRead = 1'b1;
        IorD    = 1'b0;
        ALUSrcA = A_PC;
        ALUSrcB = B_FOUR;
        ALUOp   = OP_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        PCSrc   = 1'b0;
        if (mem_ready) begin
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target OldPC+imm is parked in ALUOut ahead of S_BRANCH
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        ALUOp   = OP_ADD;
        case (opcode)
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_LD, OP_ST: state_next = S_MEM_ADDR;
          OP_BR:        state_next = S_BRANCH;
          default:      state_next = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA    = A_RS1;
        ALUSrcB    = B_RS2;
        ALUOp      = OP_FUNC;
        state_next = S_ALU_WB;
      end

      S_EXEC_I: begin
        ALUSrcA    = A_RS1;
        ALUSrcB    = B_IMM;
        ALUOp      = OP_FUNC;
        state_next = S_ALU_WB;
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b0;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        // Effective address rs1+imm; opcode picks the load or store path
        ALUSrcA = A_RS1;
        ALUSrcB = B_IMM;
        ALUOp   = OP_ADD;
        if (opcode == OP_LD) begin
          state_next = S_MEM_RD;
        end else begin
          state_next = S_MEM_WR;
        end
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        // Store retires in the cycle the memory accepts it
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
        if (mem_ready) begin
          state_next = S_FETCH;
        end
      end

      S_BRANCH: begin
        // BEQ: ALU compares rs1-rs2, PC loads the precomputed target on zero
        ALUSrcA    = A_RS1;
        ALUSrcB    = B_RS2;
        ALUOp      = OP_SUB;
        PCSrc      = 1'b1;
        PCWrite    = Zero_flg;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: begin
        // Terminal until reset
        illegal    = 1'b1;
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
